// File: rtl/rtc_bus_cycle.sv
// Read/write bus-cycle generator for the multiplexed address/data RTC interface.
// All outputs are registered and decoded from the next state, so they change on the same edge as the state.
module rtc_bus_cycle #(
    parameter int DATA_W   = 8,
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 12,
    parameter int T_HOLD   = 2,
    parameter int T_IDLE   = 4,
    parameter int CNT_W    = 5
) (
    input  logic              clkW,
    input  logic              resetAD,
    input  logic              start,
    input  logic              rw,
    input  logic              data_only,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              AD,
    output logic              CS,
    output logic              RD,
    output logic              WR,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_A_REC,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_D_REC
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                ad_q, ad_d;
    logic                cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                a_act, d_act, a_any, d_any;

    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            S_A_SETUP,  S_D_SETUP:  v = CNT_W'(T_SETUP - 1);
            S_A_STROBE, S_D_STROBE: v = CNT_W'(T_STROBE - 1);
            S_A_HOLD,   S_D_HOLD:   v = CNT_W'(T_HOLD - 1);
            S_A_REC,    S_D_REC:    v = CNT_W'(T_IDLE - 1);
            default:                v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = data_only ? S_D_SETUP : S_A_SETUP;
                end
            end
            S_A_SETUP:  if (cnt_q == '0) state_d = S_A_STROBE;
            S_A_STROBE: if (cnt_q == '0) state_d = S_A_HOLD;
            S_A_HOLD:   if (cnt_q == '0) state_d = S_A_REC;
            S_A_REC:    if (cnt_q == '0) state_d = S_D_SETUP;
            S_D_SETUP:  if (cnt_q == '0) state_d = S_D_STROBE;
            S_D_STROBE: if (cnt_q == '0) state_d = S_D_HOLD;
            S_D_HOLD:   if (cnt_q == '0) state_d = S_D_REC;
            S_D_REC:    if (cnt_q == '0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Every transition lands in a different state, so a change of state marks entry.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = load_val(state_d);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        a_act = (state_d == S_A_SETUP) || (state_d == S_A_STROBE) || (state_d == S_A_HOLD);
        d_act = (state_d == S_D_SETUP) || (state_d == S_D_STROBE) || (state_d == S_D_HOLD);
        a_any = a_act || (state_d == S_A_REC);
        d_any = d_act || (state_d == S_D_REC);

        ad_d   = !a_act;
        cs_d   = !(a_act || d_act);
        wr_d   = !((state_d == S_A_STROBE) || ((state_d == S_D_STROBE) && !rw_d));
        rd_d   = !((state_d == S_D_STROBE) && rw_d);
        oe_d   = a_act || (d_act && !rw_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_D_REC) && (cnt_q == '0);

        bus_d = '0;
        if (a_any) begin
            bus_d = addr_d;
        end else if (d_any && !rw_d) begin
            bus_d = wdata_d;
        end

        // Capture on the edge that ends the read strobe.
        rdata_d = rdata_q;
        if ((state_q == S_D_STROBE) && (cnt_q == '0) && rw_q) begin
            rdata_d = bus_in;
        end
    end

    always_ff @(posedge clkW) begin
        if (!resetAD) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ad_q    <= 1'b1;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ad_q    <= ad_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
            rdata_q <= rdata_d;
        end
    end

    // Transaction latches only matter once a cycle is running; they need no reset.
    always_ff @(posedge clkW) begin
        rw_q    <= rw_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign bus_out = bus_q;
    assign bus_oe  = oe_q;
    assign AD      = ad_q;
    assign CS      = cs_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: transaction-level timeline model checked every cycle, plus directed literal checks.
module tb_rtc_bus_cycle;

    localparam int TS  = 2;
    localparam int TST = 12;
    localparam int TH  = 2;
    localparam int TI  = 4;
    localparam int P   = TS + TST + TH;
    localparam int SEG = P + TI;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetAD = 1'b0, start = 1'b0, start2 = 1'b0, rw = 1'b0, data_only = 1'b0;
    logic [7:0] addr = 8'h00, wdata = 8'h00, bus_in = 8'h00;
    logic [7:0] bus_out, rdata, bus_out2, rdata2;
    logic       bus_oe, AD, CS, RD, WR, busy, done;
    logic       bus_oe2, AD2, CS2, RD2, WR2, busy2, done2;

    rtc_bus_cycle dut (
        .clkW(clk), .resetAD(resetAD), .start(start), .rw(rw), .data_only(data_only),
        .addr(addr), .wdata(wdata), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .AD(AD), .CS(CS), .RD(RD), .WR(WR), .busy(busy), .done(done), .rdata(rdata)
    );

    rtc_bus_cycle #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_IDLE(1)) dut2 (
        .clkW(clk), .resetAD(resetAD), .start(start2), .rw(rw), .data_only(data_only),
        .addr(addr), .wdata(wdata), .bus_in(bus_in), .bus_out(bus_out2), .bus_oe(bus_oe2),
        .AD(AD2), .CS(CS2), .RD(RD2), .WR(WR2), .busy(busy2), .done(done2), .rdata(rdata2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit         m_busy = 1'b0, m_done = 1'b0, m_rw = 1'b0, m_do = 1'b0;
    int         m_t = 0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00;

    function automatic bit in_addr_phase(input bit d, input int t);
        return !d && (t < SEG);
    endfunction

    function automatic int phase_off(input bit d, input int t);
        return (d || t < SEG) ? t : t - SEG;
    endfunction

    always @(posedge clk) begin
        if (!resetAD) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_rdata <= 8'h00;
            m_t     <= 0;
        end else if (m_busy) begin
            if (m_rw && !in_addr_phase(m_do, m_t) && phase_off(m_do, m_t) == TS + TST - 1)
                m_rdata <= bus_in;
            m_done <= (m_t == (m_do ? SEG : 2 * SEG) - 1);
            if (m_t == (m_do ? SEG : 2 * SEG) - 1) m_busy <= 1'b0;
            else m_t <= m_t + 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy  <= 1'b1;
                m_t     <= 0;
                m_rw    <= rw;
                m_do    <= data_only;
                m_addr  <= addr;
                m_wdata <= wdata;
            end
        end
    end

    // {AD,CS,RD,WR,oe,busy,done,bus_out,rdata}
    function automatic logic [22:0] expv();
        bit aph, act, stb;
        int u;
        if (!m_busy) return {4'hF, 1'b0, 1'b0, m_done, 8'h00, m_rdata};
        aph = in_addr_phase(m_do, m_t);
        u   = phase_off(m_do, m_t);
        act = (u < P);
        stb = (u >= TS) && (u < TS + TST);
        return {!(aph && act), !act, !(stb && !aph && m_rw), !(stb && (aph || !m_rw)),
                act && (aph || !m_rw), 1'b1, 1'b0,
                aph ? m_addr : (m_rw ? 8'h00 : m_wdata), m_rdata};
    endfunction

    logic prev_rd = 1'b1, prev_wr = 1'b1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs_vs_model", {AD, CS, RD, WR, bus_oe, busy, done, bus_out, rdata}, expv());
            check("rd_wr_both_low", (!RD && !WR), 1'b0);
            check("oe_while_rd_low", (!RD && bus_oe), 1'b0);
            check("strobe_fall_cs_high", (((prev_rd && !RD) || (prev_wr && !WR)) && CS), 1'b0);
        end
        prev_rd <= RD;
        prev_wr <= WR;
    end

    // ---------------- directed transactions ----------------
    logic [7:0] rd_val = 8'h00;
    int o_lat, o_ad0, o_wra, o_wrd, o_rd, o_oed, o_csgap;
    logic o_b0;

    task automatic launch(input bit r, input bit d, input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] rv);
        rw = r; data_only = d; addr = a; wdata = w; rd_val = rv; start = 1'b1;
    endtask

    task automatic observe(input logic [7:0] a, input logic [7:0] w);
        o_lat = -1; o_ad0 = 0; o_wra = 0; o_wrd = 0; o_rd = 0; o_oed = 0; o_csgap = 0; o_b0 = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start = 1'b0;
                o_b0  = busy;
                rw = 1'($urandom); data_only = 1'($urandom);
                addr = 8'($urandom); wdata = 8'($urandom);
            end
            bus_in = !RD ? rd_val : 8'($urandom);
            if (done) begin
                o_lat = t;
                break;
            end
            if (!AD) o_ad0++;
            if (!WR && !AD && bus_out == a) o_wra++;
            if (!WR && AD && bus_out == w) o_wrd++;
            if (!RD) o_rd++;
            if (bus_oe && AD) o_oed++;
            if (CS && busy) o_csgap++;
        end
    endtask

    initial begin
        int wr_lo;
        bit hit, seen;

        resetAD = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_strobes", {AD, CS, RD, WR}, 4'hF);
        check("reset_oe_busy_done", {bus_oe, busy, done}, 3'b000);
        check("reset_rdata", rdata, 8'h00);
        resetAD = 1'b1;
        repeat (2) @(negedge clk);

        launch(1'b0, 1'b0, 8'h21, 8'h47, 8'h00);
        observe(8'h21, 8'h47);
        check("wr_latency", o_lat, 40);
        check("wr_ad_low_cycles", o_ad0, 16);
        check("wr_addr_strobe", o_wra, 12);
        check("wr_data_strobe", o_wrd, 12);
        check("wr_rd_low_cycles", o_rd, 0);
        check("wr_cs_high_cycles", o_csgap, 8);

        repeat (3) @(negedge clk);
        launch(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A);
        observe(8'h10, 8'h00);
        check("rd_latency", o_lat, 40);
        check("rd_addr_strobe", o_wra, 12);
        check("rd_low_cycles", o_rd, 12);
        check("rd_data_oe_cycles", o_oed, 0);
        check("rd_rdata", rdata, 8'h5A);

        repeat (2) @(negedge clk);
        launch(1'b0, 1'b0, 8'h33, 8'h66, 8'h00);
        observe(8'h33, 8'h66);
        check("wr2_latency", o_lat, 40);
        check("wr2_rdata_kept", rdata, 8'h5A);

        repeat (2) @(negedge clk);
        launch(1'b0, 1'b1, 8'h00, 8'h09, 8'h00);
        observe(8'h00, 8'h09);
        check("do_latency", o_lat, 20);
        check("do_ad_low_cycles", o_ad0, 0);
        check("do_data_strobe", o_wrd, 12);
        launch(1'b1, 1'b1, 8'h00, 8'h00, 8'hC3);
        observe(8'h00, 8'h00);
        check("b2b_busy_next_edge", o_b0, 1'b1);
        check("b2b_latency", o_lat, 20);
        check("b2b_rdata", rdata, 8'hC3);

        // reset during the address strobe
        repeat (2) @(negedge clk);
        launch(1'b0, 1'b0, 8'h55, 8'hAA, 8'h00);
        wr_lo = 0; hit = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (!WR) wr_lo++;
            if (wr_lo == 5) begin
                hit = 1'b1;
                resetAD = 1'b0;
                break;
            end
        end
        check("rst_reached_strobe", hit, 1'b1);
        @(negedge clk);
        check("rst_mid_strobes", {AD, CS, RD, WR}, 4'hF);
        check("rst_mid_busy", busy, 1'b0);
        resetAD = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("rst_no_done", seen, 1'b0);

        // minimum timing instance, start pulses while busy must be dropped
        rw = 1'b0; data_only = 1'b0; addr = 8'h12; wdata = 8'h34;
        start2 = 1'b1;
        o_lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            start2 = (t >= 2 && t <= 6);
            if (done2) begin
                o_lat = t;
                break;
            end
        end
        check("min_latency", o_lat, 8);
        @(negedge clk);
        check("min_no_queued_start", busy2, 1'b0);
        check("min_idle_outputs", {AD2, CS2, RD2, WR2, bus_oe2, bus_out2, rdata2}, {4'hF, 1'b0, 16'h0000});

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start     = ($urandom % 6) == 0;
            rw        = 1'($urandom);
            data_only = 1'($urandom);
            addr      = 8'($urandom);
            wdata     = 8'($urandom);
            bus_in    = 8'($urandom);
            resetAD   = ($urandom % 400) != 0;
        end
        @(negedge clk);
        start = 1'b0;
        resetAD = 1'b1;
        repeat (100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Parametrised read/write bus-cycle generator for the multiplexed address/data RTC interface. It replaces the fixed write-only timing generator. A transaction is requested with a single-cycle handshake. The block then produces the complete AD/CS/RD/WR strobe sequence: an optional address phase followed by a data phase that is either a write or a read. It drives the shared bus through output-enable signals, and the top level instantiates the tri-state pad. Read data is captured and returned.

## Interface
- DATA_W, 8, width of the multiplexed address/data bus
- T_SETUP, 2, cycles CS low with bus valid before the strobe falls (≥1)
- T_STROBE, 12, cycles RD or WR held low (≥1)
- T_HOLD, 2, cycles CS low and bus held after the strobe rises (≥1)
- T_IDLE, 4, cycles CS high after each phase (≥1)
- CNT_W, 5, phase counter width; must hold max(T_*)−1
- clkW  in  1  single clock, rising edge
- resetAD  in  1  synchronous, active-low reset
- start  in  1  transaction request, sampled only in IDLE
- rw  in  1  1 = read data phase, 0 = write data phase
- data_only  in  1  1 = skip the address phase
- addr  in  DATA_W  register address
- wdata  in  DATA_W  write data
- bus_in  in  DATA_W  bus value from the pad
- bus_out  out  DATA_W  value to drive onto the bus
- bus_oe  out  1  pad output enable, active high
- AD  out  1  0 = address phase, 1 = data phase or idle
- CS, RD, WR  out  1  active-low chip strobes
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  last captured read data

## Operation
- Reset (resetAD=0 at an edge), regardless of the current state:
  - forces IDLE;
  - sets AD=CS=RD=WR=1, bus_oe=0, bus_out=0, busy=0, done=0, rdata=0;
  - clears the counter;
  - never emits done.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, A_REC, D_SETUP, D_STROBE, D_HOLD, D_REC.
- IDLE with start=1:
  - latches rw, data_only, addr and wdata;
  - moves to A_SETUP, or to D_SETUP if data_only=1.
  - Input changes after acceptance are ignored.
- Each timed state loads the counter with T_x−1 on entry and leaves when the counter reaches 0. The chain is SETUP→STROBE→HOLD→REC. A_REC moves to D_SETUP; D_REC moves to IDLE.
- Address phase (A_*):
  - AD=0, bus_out=addr.
  - bus_oe=1 in SETUP, STROBE and HOLD.
  - CS=0 in SETUP, STROBE and HOLD.
  - WR=0 only in A_STROBE; RD=1 throughout.
- Write data phase:
  - AD=1, bus_out=wdata, bus_oe=1 in SETUP, STROBE and HOLD.
  - CS=0 in SETUP, STROBE and HOLD.
  - WR=0 only in D_STROBE.
- Read data phase:
  - AD=1, bus_oe=0 for the whole phase.
  - CS=0 in SETUP, STROBE and HOLD.
  - RD=0 only in D_STROBE.
  - bus_in is sampled into rdata at the edge that leaves D_STROBE.
- REC states: CS=1, bus_oe=0, AD=1 in both A_REC and D_REC.
- Exiting D_REC sets done=1 for exactly the first IDLE cycle. A start in that same cycle is accepted.
- Invariants checked by the bench:
  - RD and WR are never low together.
  - bus_oe=0 whenever RD=0.
  - Strobes fall only while CS=0.
- start while busy=1 is ignored and not queued.
- rdata changes only on read completion; write transactions leave it untouched.

## Timing
- All outputs come from flops updated on the same edge as the state. There are no combinational paths from inputs to outputs.
- Edge k samples start=1 in IDLE. From edge k onward: busy=1, CS=0, AD=0 (or AD=1 if data_only).
- Phase length is P = T_SETUP+T_STROBE+T_HOLD; the strobe-low window is exactly T_STROBE cycles.
- Full transaction: 2·P+2·T_IDLE cycles from acceptance to the first IDLE cycle, so done appears at cycle k+2·P+2·T_IDLE. With default parameters this is 40 cycles.
- data_only transaction: P+T_IDLE cycles. With default parameters this is 20 cycles.
- rdata is valid from the edge ending D_STROBE. Throughput is one transaction per (latency+1) cycles with back-to-back starts.

## Test plan
- Reset: hold resetAD=0 for 3 edges mid-idle → AD=CS=RD=WR=1, bus_oe=0, busy=0, done=0, rdata=0x00.
- Write, defaults: addr=0x21, wdata=0x47, rw=0.
  - Address phase: AD=0 for 16 cycles; WR low for 12 cycles with bus_out=0x21.
  - Then 4 cycles with CS=1.
  - Data phase: AD=1, WR low for 12 cycles with bus_out=0x47.
  - done at cycle 40.
- Read: addr=0x10, rw=1, bus_in=0x5A during D_STROBE.
  - bus_oe=0 for the whole data phase; RD low for 12 cycles.
  - rdata=0x5A at done.
  - A later write leaves rdata=0x5A.
- data_only write: wdata=0x09 → no AD=0 cycles, done at cycle 20. A start asserted in the done cycle begins a new cycle on the next edge.
- Reset mid-strobe: assert resetAD=0 at the 5th WR-low cycle → next edge gives all strobes high, busy=0, and done never pulses.
- Override T_SETUP=T_STROBE=T_HOLD=T_IDLE=1: full write → done at cycle 8; start pulses at cycles 2–6 are ignored.
